pc_sequencer: RTL and testbench

- Program-flow controller for the 9-bit processor. It owns the 10-bit program counter and runs the Start/Done handshake with the test harness.
- It takes the control decoder's branch, load and Ack outputs plus the ALU compare flags, and decides each cycle whether to advance, branch, stall for a load, or halt.
- Sits between the control decoder and the instruction ROM address input. It also gates register-file and memory writes while the core is idle or stalled.

---
 rtl/pc_sequencer_pkg.sv | 46 ++++
 rtl/pc_sequencer_branch_target_unit.sv | 47 ++++
 rtl/pc_sequencer.sv | 158 +++++++++++++++
 tb/tb_pc_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared definitions for the program-flow controller of the 9-bit core:
//   - seq_state_t        : sequencer FSM states
//   - kCond*             : BranchConditions encodings
//   - kAbsTarget         : absolute branch target LUT (10-bit, index 0..3)
//   - kRelOffset         : relative branch offset LUT (10-bit two's complement)
//   - cond_true()        : evaluates a branch condition against the ALU flags
// ---------------------------------------------------------------------------
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RUN       = 2'd1,
      LOAD_WAIT = 2'd2,
      HALT      = 2'd3
   } seq_state_t;

   localparam logic [1:0] kCondAlways = 2'b00;
   localparam logic [1:0] kCondZero   = 2'b01;
   localparam logic [1:0] kCondNZ     = 2'b10;
   localparam logic [1:0] kCondNeg    = 2'b11;

   localparam int kLutW = 10;

   // Packed so that element [0] is the rightmost entry: index 0..3 = 0,16,64,200
   localparam logic [3:0][kLutW-1:0] kAbsTarget = {10'd200, 10'd64, 10'd16, 10'd0};
   // Index 0..3 = -4, -8, +4, +12 (two's complement, sign-extended at use)
   localparam logic [3:0][kLutW-1:0] kRelOffset = {10'd12, 10'd4, 10'h3F8, 10'h3FC};

   function automatic logic cond_true(input logic [1:0] cond,
                                      input logic       zero_flag,
                                      input logic       neg_flag);
      logic res;
      res = 1'b1;
      case (cond)
         kCondAlways: res = 1'b1;
         kCondZero:   res = zero_flag;
         kCondNZ:     res = ~zero_flag;
         kCondNeg:    res = neg_flag;
         default:     res = 1'b1;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/pc_sequencer_branch_target_unit.sv
// ---------------------------------------------------------------------------
// branch_target_unit
// Purely combinational branch resolution: decides whether a branch is taken
// from the condition code and the registered ALU flags, and computes the
// target address from the LUT index (absolute or PC-relative).
// Ports:
//   pc                 in  PC_W  current program counter
//   pc_targ            in  2     LUT index
//   branch_abs_or_rel  in  1     0 = absolute target, 1 = relative offset
//   branch_conditions  in  2     condition code (always/zero/not-zero/neg)
//   zero_flag          in  1     ALU zero flag
//   neg_flag           in  1     ALU negative flag
//   taken              out 1     condition evaluates true
//   target             out PC_W  branch destination address
// ---------------------------------------------------------------------------
module branch_target_unit
   import pc_sequencer_pkg::*;
#(
   parameter int unsigned PC_W = 10
) (
   input  logic [PC_W-1:0] pc,
   input  logic [1:0]      pc_targ,
   input  logic            branch_abs_or_rel,
   input  logic [1:0]      branch_conditions,
   input  logic            zero_flag,
   input  logic            neg_flag,
   output logic            taken,
   output logic [PC_W-1:0] target
);

   logic [kLutW-1:0] rel_off;
   logic [PC_W-1:0]  rel_off_ext;

   always_comb begin
      taken       = cond_true(branch_conditions, zero_flag, neg_flag);
      rel_off     = kRelOffset[pc_targ];
      // Sign-extend the LUT offset; the add then wraps modulo 2^PC_W in
      // both directions.
      rel_off_ext = PC_W'($signed(rel_off));
      if (branch_abs_or_rel) begin
         target = pc + rel_off_ext;
      end else begin
         target = PC_W'(kAbsTarget[pc_targ]);
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Program-flow controller for the 9-bit processor. Owns the program counter,
// runs the Start/Done handshake, stalls the PC for loads, resolves branches
// and gates architectural writes (CommitEn) while idle, stalled or halted.
// Ports:
//   Clk               in  1      system clock
//   Reset             in  1      synchronous active-high reset
//   Start             in  1      begin execution (from IDLE or HALT)
//   ConditionalJump   in  1      decoder: branch instruction
//   BranchAbsOrRel    in  1      decoder: 0 absolute, 1 relative
//   BranchConditions  in  2      decoder: condition code
//   PCTarg            in  2      decoder: branch LUT index
//   LoadInst          in  1      decoder: memory load
//   Ack               in  1      decoder: halt instruction
//   ZeroFlag          in  1      ALU zero flag
//   NegFlag           in  1      ALU negative flag
//   ProgCtr           out PC_W   instruction ROM address (registered)
//   CommitEn          out 1      instruction may write reg file / memory
//   Stall             out 1      PC held waiting for load data
//   Done              out 1      program halted (registered)
//   CycleCount        out CNT_W  RUN + LOAD_WAIT cycles since last Start
// ---------------------------------------------------------------------------
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int unsigned PC_W       = 10,
   parameter int unsigned START_ADDR = 0,
   parameter int unsigned LOAD_LAT   = 1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             ConditionalJump,
   input  logic             BranchAbsOrRel,
   input  logic [1:0]       BranchConditions,
   input  logic [1:0]       PCTarg,
   input  logic             LoadInst,
   input  logic             Ack,
   input  logic             ZeroFlag,
   input  logic             NegFlag,
   output logic [PC_W-1:0]  ProgCtr,
   output logic             CommitEn,
   output logic             Stall,
   output logic             Done,
   output logic [CNT_W-1:0] CycleCount
);

   localparam int unsigned WAIT_W = 3;   // covers LOAD_LAT up to 7

   seq_state_t        state_reg, state_next;
   logic [PC_W-1:0]   pc_reg, pc_next;
   logic [CNT_W-1:0]  cc_reg, cc_next, cc_inc;
   logic [WAIT_W-1:0] wait_reg, wait_next;
   logic              done_reg, done_next;

   logic              br_taken;
   logic [PC_W-1:0]   br_target;

   branch_target_unit #(
      .PC_W (PC_W)
   ) u_btu (
      .pc                (pc_reg),
      .pc_targ           (PCTarg),
      .branch_abs_or_rel (BranchAbsOrRel),
      .branch_conditions (BranchConditions),
      .zero_flag         (ZeroFlag),
      .neg_flag          (NegFlag),
      .taken             (br_taken),
      .target            (br_target)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg <= IDLE;
         pc_reg    <= '0;
         cc_reg    <= '0;
         wait_reg  <= '0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         cc_reg    <= cc_next;
         wait_reg  <= wait_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      cc_next    = cc_reg;
      wait_next  = wait_reg;
      done_next  = done_reg;
      // Saturating increment of the executed-cycle counter
      cc_inc     = (cc_reg == '1) ? cc_reg : cc_reg + CNT_W'(1);

      case (state_reg)
         IDLE: begin
            if (Start) begin
               state_next = RUN;
               pc_next    = PC_W'(START_ADDR);
               cc_next    = '0;
               done_next  = 1'b0;
            end
         end
         RUN: begin
            cc_next = cc_inc;
            // Ack must beat ConditionalJump: the halt opcode also decodes
            // as a branch.
            if (Ack) begin
               state_next = HALT;
               done_next  = 1'b1;
            end else if (LoadInst) begin
               state_next = LOAD_WAIT;
               wait_next  = WAIT_W'(LOAD_LAT);
            end else if (ConditionalJump && br_taken) begin
               pc_next = br_target;
            end else begin
               pc_next = pc_reg + PC_W'(1);
            end
         end
         LOAD_WAIT: begin
            // Decoder inputs are deliberately ignored here; the held PC
            // keeps presenting the load instruction.
            cc_next = cc_inc;
            if (wait_reg == '0) begin
               state_next = RUN;
               pc_next    = pc_reg + PC_W'(1);
            end else begin
               wait_next = wait_reg - WAIT_W'(1);
            end
         end
         HALT: begin
            if (Start) begin
               state_next = RUN;
               pc_next    = PC_W'(START_ADDR);
               cc_next    = '0;
               done_next  = 1'b0;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The final LOAD_WAIT cycle (counter exhausted) is the one that commits
   // the load result.
   assign CommitEn   = (state_reg == RUN) ||
                       ((state_reg == LOAD_WAIT) && (wait_reg == '0));
   assign Stall      = (state_reg == LOAD_WAIT) && (wait_reg != '0);
   assign ProgCtr    = pc_reg;
   assign Done       = done_reg;
   assign CycleCount = cc_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Directed vectors drive pc_sequencer (LOAD_LAT = 3). Each vector pushes the
// outputs expected during that cycle into a scoreboard queue; a monitor pops
// one entry per cycle on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        cj;
   logic        rel;
   logic [1:0]  cond;
   logic [1:0]  targ;
   logic        ld;
   logic        ack;
   logic        zf;
   logic        nf;
   logic [9:0]  prog_ctr;
   logic        commit_en;
   logic        stall;
   logic        done;
   logic [15:0] cycle_count;

   int checks   = 0;
   int failures = 0;
   int vec_idx  = 0;
   bit stim_done = 1'b0;

   typedef struct {
      int          idx;
      bit          chk;
      logic [9:0]  pc;
      logic        ce;
      logic        st;
      logic        dn;
      logic [15:0] cc;
   } exp_t;

   exp_t sb[$];

   pc_sequencer #(
      .PC_W       (10),
      .START_ADDR (0),
      .LOAD_LAT   (3),
      .CNT_W      (16)
   ) dut (
      .Clk              (clk),
      .Reset            (rst),
      .Start            (start),
      .ConditionalJump  (cj),
      .BranchAbsOrRel   (rel),
      .BranchConditions (cond),
      .PCTarg           (targ),
      .LoadInst         (ld),
      .Ack              (ack),
      .ZeroFlag         (zf),
      .NegFlag          (nf),
      .ProgCtr          (prog_ctr),
      .CommitEn         (commit_en),
      .Stall            (stall),
      .Done             (done),
      .CycleCount       (cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL vec %0d %s: got %0d expected %0d", idx, name, act, exp);
      end
   endtask

   // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
               $display("vec %0d: pc=%0d ce=%0b st=%0b dn=%0b cc=%0d", e.idx,
                        prog_ctr, commit_en, stall, done, cycle_count);
               cmp("ProgCtr",    e.idx, int'(prog_ctr),    int'(e.pc));
               cmp("CommitEn",   e.idx, int'(commit_en),   int'(e.ce));
               cmp("Stall",      e.idx, int'(stall),       int'(e.st));
               cmp("Done",       e.idx, int'(done),        int'(e.dn));
               cmp("CycleCount", e.idx, int'(cycle_count), int'(e.cc));
            end
         end
      end
   end

   // Drive one cycle of inputs and queue the outputs expected during it.
   task automatic v(input logic r, input logic s, input logic j, input logic rl,
                    input logic [1:0] c, input logic [1:0] t, input logic l,
                    input logic a, input logic z, input logic n,
                    input bit chk, input int epc, input logic ece,
                    input logic est, input logic edn, input int ecc);
      exp_t e;
      rst   = r;  start = s;  cj  = j;  rel = rl;
      cond  = c;  targ  = t;  ld  = l;  ack = a;
      zf    = z;  nf    = n;
      e.idx = vec_idx;
      e.chk = chk;
      e.pc  = 10'(epc);
      e.ce  = ece;
      e.st  = est;
      e.dn  = edn;
      e.cc  = 16'(ecc);
      sb.push_back(e);
      vec_idx++;
      @(posedge clk);
      #1;
   endtask

   // Shorthand for a RUN-cycle non-branch instruction with given expectation
   task automatic nop(input int epc, input int ecc);
      v(0,0,0,0,2'b00,2'b00,0,0,0,0, 1, epc,1,0,0, ecc);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; cj = 1'b0; rel = 1'b0; cond = 2'b00;
      targ = 2'b00; ld = 1'b0; ack = 1'b0; zf = 1'b0; nf = 1'b0;
      @(posedge clk);
      #1;
      //  r s j rl cond  targ  l a z n  chk pc  ce st dn cc
      v(1,0,0,0,2'b00,2'b00,0,0,0,0, 0,    0,0,0,0, 0);  // outputs unknown yet
      v(1,0,0,0,2'b00,2'b00,0,0,0,0, 1,    0,0,0,0, 0);  // reset state
      v(0,0,0,0,2'b00,2'b00,0,0,0,0, 1,    0,0,0,0, 0);  // IDLE, no start
      v(0,1,0,0,2'b00,2'b00,0,0,0,0, 1,    0,0,0,0, 0);  // Start pulse
      nop(0, 0);
      nop(1, 1);
      nop(2, 2);
      nop(3, 3);
      v(0,1,0,0,2'b00,2'b00,0,0,0,0, 1,    4,1,0,0, 4);  // Start in RUN ignored
      // PC=5, CC=5; absolute branch back to 0
      v(0,0,1,0,2'b00,2'b00,0,0,0,0, 1,    5,1,0,0, 5);
      nop(0, 6);
      nop(1, 7);
      v(0,0,1,1,2'b00,2'b00,0,0,0,0, 1,    2,1,0,0, 8);  // rel -4 -> 1022
      nop(1022, 9);
      nop(1023, 10);                                     // wraps to 0
      v(0,0,1,0,2'b01,2'b01,0,0,1,0, 1,    0,1,0,0, 11); // abs 16, zero true
      v(0,0,1,1,2'b10,2'b10,0,0,0,0, 1,   16,1,0,0, 12); // rel +4, NZ true -> 20
      v(0,0,1,0,2'b00,2'b10,0,0,0,0, 1,   20,1,0,0, 13); // abs 64
      v(0,0,1,1,2'b01,2'b01,0,0,0,0, 1,   64,1,0,0, 14); // zero false -> 65
      v(0,0,1,0,2'b00,2'b10,0,0,0,0, 1,   65,1,0,0, 15); // abs 64
      v(0,0,1,1,2'b01,2'b01,0,0,1,0, 1,   64,1,0,0, 16); // zero true -> 56
      v(0,0,1,0,2'b11,2'b11,0,0,0,0, 1,   56,1,0,0, 17); // neg false -> 57
      v(0,0,1,0,2'b11,2'b01,0,0,0,1, 1,   57,1,0,0, 18); // neg true -> 16
      v(0,0,1,1,2'b10,2'b01,0,0,0,0, 1,   16,1,0,0, 19); // rel -8 -> 8
      nop(8, 20);
      nop(9, 21);
      v(0,0,0,0,2'b00,2'b00,1,0,0,0, 1,   10,1,0,0, 22); // load at 10
      v(0,0,1,0,2'b00,2'b11,0,0,0,0, 1,   10,0,1,0, 23); // decoder ignored
      v(0,0,0,0,2'b00,2'b00,1,0,0,0, 1,   10,0,1,0, 24);
      v(0,0,0,0,2'b00,2'b00,0,1,0,0, 1,   10,0,1,0, 25);
      v(0,0,0,0,2'b00,2'b00,0,0,0,0, 1,   10,1,0,0, 26); // load commits
      v(0,0,1,0,2'b00,2'b01,0,0,0,0, 1,   11,1,0,0, 27); // abs 16
      v(0,0,1,1,2'b00,2'b11,0,0,0,0, 1,   16,1,0,0, 28); // rel +12 -> 28
      nop(28, 29);
      nop(29, 30);
      v(0,0,1,0,2'b00,2'b11,0,1,0,0, 1,   30,1,0,0, 31); // 1FF: halt wins
      v(0,0,0,0,2'b00,2'b00,0,0,0,0, 1,   30,0,0,1, 32);
      v(0,0,1,0,2'b00,2'b10,0,0,0,0, 1,   30,0,0,1, 32);
      v(0,1,0,0,2'b00,2'b00,0,0,0,0, 1,   30,0,0,1, 32); // restart
      v(0,0,0,0,2'b00,2'b00,0,0,0,0, 1,    0,1,0,0, 0);
      v(0,0,0,0,2'b00,2'b00,1,0,0,0, 1,    1,1,0,0, 1);  // load at 1
      v(1,0,0,0,2'b00,2'b00,0,0,0,0, 1,    1,0,1,0, 2);  // reset mid-wait
      v(0,1,0,0,2'b00,2'b00,0,0,0,0, 1,    0,0,0,0, 0);  // IDLE after reset
      v(0,1,0,0,2'b00,2'b00,0,1,0,0, 1,    0,1,0,0, 0);  // halt, Start held
      v(0,1,0,0,2'b00,2'b00,0,0,0,0, 1,    0,0,0,1, 1);  // single HALT cycle
      nop(0, 0);
      nop(1, 1);
      stim_done = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      if (!stim_done) begin
         $display("FAIL timeout: got stimulus incomplete expected complete");
         $fatal(1, "timeout");
      end
   end

endmodule
